// File: rtl/seq_decade_pkg.sv
// Shared types and helpers for the decade-counter wrap accumulator.
// Digits are plain 4-bit BCD values. next_digit() gives the mod-10 successor.
package seq_decade_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t DIGIT_MAX = 4'd9;

    // Any value at or above 9 maps to 0. Callers only pass legal digits,
    // so this covers 9 -> 0 and the guard keeps the result a legal digit.
    function automatic digit_t next_digit(input digit_t d);
        return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seq_decade_wrap_accum_if.sv
// Bus between the upstream decade counter side and the wrap accumulator.
// The master drives the sampled digit and enable.
// The slave (the accumulator) drives the wrap carry, BCD count and sticky flags.
interface seq_decade_wrap_accum_if #(parameter int NUM_DIGITS = 2);

    logic                    en;
    seq_decade_pkg::digit_t  in;
    logic                    carry;
    logic [4*NUM_DIGITS-1:0] count;
    logic                    overflow;
    logic                    err;

    modport master (output en, in, input carry, count, overflow, err);
    modport slave  (input en, in, output carry, count, overflow, err);

endinterface

// File: rtl/seq_bcd_digit.sv
// One BCD digit of the wrap counter.
// The digit advances mod 10 when inc_in is high.
// carry_out tells the next digit up that this digit is rolling over from 9.
module seq_bcd_digit
    import seq_decade_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   inc_in,
    output digit_t value,
    output logic   carry_out
);

    // Digit register: synchronous clear, otherwise advance on an increment request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value <= '0;
        end else if (inc_in) begin
            value <= next_digit(value);
        end
    end

    assign carry_out = inc_in & (value == DIGIT_MAX);

endmodule

// File: rtl/seq_decade_wrap_accum.sv
// Checks the digit stream from an upstream decade counter and counts its 9->0 wraps.
// Each wrap produces a one-cycle carry and bumps a NUM_DIGITS-digit BCD count.
// Illegal digits or steps set a sticky err.
// NUM_DIGITS is meant to lie in 1..4.
module seq_decade_wrap_accum
    import seq_decade_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    seq_decade_wrap_accum_if.slave  bus
);

    digit_t                  prev;
    logic                    primed;
    logic                    carry_q;
    logic                    err_q;
    logic                    overflow_q;

    logic                    digit_legal;
    logic                    step_ok;
    logic                    wrap;
    logic                    bad_sample;

    logic [NUM_DIGITS:0]     inc_chain;
    digit_t                  digit_val [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] count_w;

    // Classify the current sample. A wrap is only recognised once primed.
    // Any legal-digit step other than the mod-10 successor counts as an error,
    // and that includes a repeated digit.
    always_comb begin
        digit_legal = (bus.in <= DIGIT_MAX);
        step_ok     = (bus.in == next_digit(prev));
        wrap        = bus.en & digit_legal & primed & (prev == DIGIT_MAX) & (bus.in == '0);
        bad_sample  = bus.en & (~digit_legal | (primed & ~step_ok));
    end

    assign inc_chain[0] = wrap;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            seq_bcd_digit u_digit (
                .clk       (clk),
                .reset_n   (reset_n),
                .inc_in    (inc_chain[g]),
                .value     (digit_val[g]),
                .carry_out (inc_chain[g+1])
            );
            assign count_w[4*g +: 4] = digit_val[g];
        end
    endgenerate

    // Step tracker and flag registers.
    // After an illegal digit the block re-primes on the next legal one.
    // A carry out of the top digit means the count rolled past all 9s.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev       <= '0;
            primed     <= 1'b0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            carry_q <= wrap;
            if (bus.en) begin
                if (!digit_legal) begin
                    primed <= 1'b0;
                end else begin
                    prev   <= bus.in;
                    primed <= 1'b1;
                end
            end
            if (bad_sample) begin
                err_q <= 1'b1;
            end
            if (inc_chain[NUM_DIGITS]) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.carry    = carry_q;
    assign bus.count    = count_w;
    assign bus.overflow = overflow_q;
    assign bus.err      = err_q;

endmodule
